// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 types, constants and helper functions (S-box,
//            rcon, RotWord, GF(2^8) multiply) for the key-schedule block.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [0:31] word_t;

    localparam int c_NK = 4;
    localparam int c_NR = 10;

    localparam logic [0:2047] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] SBox(input logic [7:0] a);
        return c_SBOX[{a, 3'b000} +: 8];
    endfunction

    function automatic word_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 32'h01000000;
            4'd2:    return 32'h02000000;
            4'd3:    return 32'h04000000;
            4'd4:    return 32'h08000000;
            4'd5:    return 32'h10000000;
            4'd6:    return 32'h20000000;
            4'd7:    return 32'h40000000;
            4'd8:    return 32'h80000000;
            4'd9:    return 32'h1b000000;
            4'd10:   return 32'h36000000;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic word_t RotWord(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (up to 15) via shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] r;
        p = b;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) r = r ^ p;
            p = gf_mul2(p);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_sched_if
// Purpose  : Start/key request and round-key valid/ready stream bundle.
// Revision : 1.0
// ============================================================================
interface aes_inv_key_sched_if;

    logic          start;
    logic [0:127]  key;
    logic          busy;
    logic          rk_valid;
    logic          rk_ready;
    logic [0:127]  rk;
    logic [3:0]    rk_round;
    logic          rk_last;

    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, rk, rk_round, rk_last
    );

    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, rk, rk_round, rk_last
    );

endinterface
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_word
// Purpose  : SubWord - four parallel S-box lookups, purely combinational.
// Revision : 1.0
// ============================================================================
module aes_sub_word
    import aes_pkg::*;
(
    input  wire word_t i_word,
    output word_t      o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign o_word[8*g +: 8] = SBox(i_word[8*g +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_sched
// Purpose  : AES-128 decryption round-key generator: runs the forward schedule
//            to round 10, then streams keys 10..0 using the inverse step.
//            Option macro AES_INV_KEY_EQ_INV_MIXCOL_EN: InvMixColumns on
//            rounds 1..9 for the equivalent inverse cipher.
// Revision : 1.0
// ============================================================================
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NK = c_NK,
    parameter int NR = c_NR
)(
    input  wire logic clk,
    input  wire logic rst,
    aes_inv_key_sched_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FWD  = 2'd1;
    localparam logic [1:0] c_EMIT = 2'd2;
    localparam int         c_LASTW = 32 * (NK - 1);

    logic [1:0]   r_state;
    logic [3:0]   r_rcnt;
    logic [0:127] r_work;
    logic         r_busy;
    logic         r_rkValid;
    logic         r_rkLast;

    word_t        w_subIn;
    word_t        w_rotIn;
    word_t        w_subOut;
    word_t        w_rcon;
    logic [3:0]   w_rconIdx;
    logic [0:127] w_fwd;
    logic [0:127] w_inv;
    logic [0:127] w_rkOut;

    // In EMIT the inverse step needs the previous w3, which is n3 ^ n2.
    assign w_subIn   = (r_state == c_EMIT) ? (r_work[c_LASTW +: 32] ^ r_work[c_LASTW-32 +: 32])
                                           : r_work[c_LASTW +: 32];
    assign w_rotIn   = RotWord(w_subIn);
    assign w_rconIdx = (r_state == c_EMIT) ? r_rcnt : (r_rcnt + 4'd1);
    assign w_rcon    = rcon(w_rconIdx);

    aes_sub_word u_subWord (
        .i_word (w_rotIn),
        .o_word (w_subOut)
    );

    always_comb begin
        w_fwd = '0;
        w_inv = '0;
        w_fwd[0:31] = r_work[0:31] ^ w_subOut ^ w_rcon;
        for (int i = 1; i < NK; i++) begin
            w_fwd[32*i +: 32] = r_work[32*i +: 32] ^ w_fwd[32*(i-1) +: 32];
            w_inv[32*i +: 32] = r_work[32*i +: 32] ^ r_work[32*(i-1) +: 32];
        end
        w_inv[0:31] = r_work[0:31] ^ w_subOut ^ w_rcon;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_rcnt    <= 4'd0;
            r_work    <= '0;
            r_busy    <= 1'b0;
            r_rkValid <= 1'b0;
            r_rkLast  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_work  <= bus.key;
                        r_rcnt  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_FWD;
                    end
                end
                c_FWD: begin
                    r_work <= w_fwd;
                    r_rcnt <= r_rcnt + 4'd1;
                    if (r_rcnt == 4'(NR - 1)) begin
                        r_state   <= c_EMIT;
                        r_rkValid <= 1'b1;
                        r_rkLast  <= 1'b0;
                    end
                end
                c_EMIT: begin
                    if (bus.rk_ready) begin
                        if (r_rcnt != 4'd0) begin
                            r_work   <= w_inv;
                            r_rcnt   <= r_rcnt - 4'd1;
                            r_rkLast <= (r_rcnt == 4'd1);
                        end else begin
                            r_state   <= c_IDLE;
                            r_busy    <= 1'b0;
                            r_rkValid <= 1'b0;
                            r_rkLast  <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef AES_INV_KEY_EQ_INV_MIXCOL_EN
    function automatic word_t invMixCol(input word_t c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0:7];
        a1 = c[8:15];
        a2 = c[16:23];
        a3 = c[24:31];
        return {gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
                gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
                gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
                gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)};
    endfunction

    logic [0:127] w_imc;
    for (genvar g = 0; g < NK; g++) begin : g_imc
        assign w_imc[32*g +: 32] = invMixCol(r_work[32*g +: 32]);
    end

    // First and last round keys feed AddRoundKey directly and stay raw.
    assign w_rkOut = (r_rcnt != 4'd0 && r_rcnt != 4'(NR)) ? w_imc : r_work;
`else
    assign w_rkOut = r_work;
`endif

    assign bus.busy     = r_busy;
    assign bus.rk_valid = r_rkValid;
    assign bus.rk       = w_rkOut;
    assign bus.rk_round = r_rcnt;
    assign bus.rk_last  = r_rkLast;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_key_sched
// Purpose  : Scoreboard bench for aes_inv_key_sched using FIPS-197 vectors.
// Revision : 1.0
// ============================================================================
module tb_aes_inv_key_sched;

    typedef struct {
        logic [0:127] rk;
        logic [3:0]   rnd;
        logic         last;
        bit           chk;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [0:127] kA [11];
    logic [0:127] kB0;
    logic [0:127] kB10;

    aes_inv_key_sched_if bus();

    aes_inv_key_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [7:0] m9 (input logic [7:0] x); return xt(xt(xt(x))) ^ x; endfunction
    function automatic logic [7:0] m11(input logic [7:0] x); return xt(xt(xt(x))) ^ xt(x) ^ x; endfunction
    function automatic logic [7:0] m13(input logic [7:0] x); return xt(xt(xt(x))) ^ xt(xt(x)) ^ x; endfunction
    function automatic logic [7:0] m14(input logic [7:0] x); return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x); endfunction

    function automatic logic [0:127] invMixTb(input logic [0:127] k);
        logic [0:127] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = k[32*c +: 8];
            a1 = k[32*c+8 +: 8];
            a2 = k[32*c+16 +: 8];
            a3 = k[32*c+24 +: 8];
            r[32*c    +: 8] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
            r[32*c+8  +: 8] = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
            r[32*c+16 +: 8] = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
            r[32*c+24 +: 8] = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);
        end
        return r;
    endfunction

    function automatic logic [0:127] expRk(input logic [0:127] raw, input int r);
`ifdef AES_INV_KEY_EQ_INV_MIXCOL_EN
        if (r >= 1 && r <= 9) return invMixTb(raw);
`endif
        return raw;
    endfunction

    task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pushSeq(input bit useB);
        exp_t e;
        logic [0:127] raw;
        for (int r = 10; r >= 0; r--) begin
            if (useB) raw = (r == 10) ? kB10 : ((r == 0) ? kB0 : '0);
            else      raw = kA[r];
            e.rk   = expRk(raw, r);
            e.rnd  = 4'(r);
            e.last = (r == 0);
            e.chk  = !useB || r == 10 || r == 0;
            sb.push_back(e);
        end
    endtask

    task automatic doStart(input logic [0:127] k);
        bus.start = 1'b1;
        bus.key   = k;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_busy"},     128'(bus.busy),     '0);
        check({tag, "_rk_valid"}, 128'(bus.rk_valid), '0);
        check({tag, "_rk"},       bus.rk,             '0);
        check({tag, "_rk_round"}, 128'(bus.rk_round), '0);
        check({tag, "_rk_last"},  128'(bus.rk_last),  '0);
    endtask

    task automatic drain(input string tag, input bit randomReady);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 400) begin
            @(posedge clk);
            #1;
            if (randomReady) bus.rk_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check({tag, "_queue_left"}, 128'(sb.size()), '0);
        check({tag, "_busy_end"},   128'(bus.busy),  '0);
        check({tag, "_valid_end"},  128'(bus.rk_valid), '0);
    endtask

    task automatic waitRound(input string tag, input int rnd);
        int n = 0;
        while (!(bus.rk_valid && bus.rk_round == 4'(rnd)) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_reach_round"}, 128'(bus.rk_valid && bus.rk_round == 4'(rnd)), 128'(1));
    endtask

    task automatic stimulus();
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkZero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic stream with latency measurement
        bus.rk_ready = 1'b1;
        pushSeq(1'b0);
        doStart(kA[0]);
        n = 0;
        while (!bus.rk_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", 128'(n), 128'(10));
        check("busy_during", 128'(bus.busy), 128'(1));
        drain("basic", 1'b0);

        // Ignored starts, stall at round 7, then random ready
        pushSeq(1'b0);
        doStart(kA[0]);
        repeat (3) @(posedge clk);
        #1;
        doStart(kB0);
        waitRound("stall", 7);
        bus.rk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.start = (i == 2);
            bus.key   = kB0;
            check("hold_rk", bus.rk, expRk(kA[7], 7));
            check("hold_round", 128'(bus.rk_round), 128'(7));
            check("hold_last", 128'(bus.rk_last), '0);
        end
        bus.start = 1'b0;
        drain("random_ready", 1'b1);

        // Reset during the forward walk
        bus.rk_ready = 1'b1;
        doStart(kA[0]);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkZero("rst_fwd");
        rst = 1'b0;

        // Reset during emission at round 4
        pushSeq(1'b0);
        doStart(kA[0]);
        waitRound("rst_emit", 4);
        bus.rk_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checkZero("rst_emit");
        rst = 1'b0;
        bus.rk_ready = 1'b1;

        // Fresh key after reset
        pushSeq(1'b1);
        doStart(kB0);
        drain("key_b", 1'b0);

        // Back-to-back: restart on the cycle after the last handshake
        pushSeq(1'b0);
        doStart(kA[0]);
        n = 0;
        while (!(bus.rk_valid && bus.rk_last) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_reach_last", 128'(bus.rk_valid && bus.rk_last), 128'(1));
        pushSeq(1'b0);
        @(posedge clk);
        #1;
        doStart(kA[0]);
        check("b2b_busy", 128'(bus.busy), 128'(1));
        drain("b2b", 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key = '0;
        bus.rk_ready = 1'b0;
        kA = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'ha0fafe1788542cb123a339392a6c7605,
               128'hf2c295f27a96b9435935807a7359f67f,
               128'h3d80477d4716fe3e1e237e446d7a883b,
               128'hef44a541a8525b7fb671253bdb0bad00,
               128'hd4d1c6f87c839d87caf2b8bc11f915bc,
               128'h6d88a37a110b3efddbf98641ca0093fd,
               128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
               128'head27321b58dbad2312bf5607f8d292f,
               128'hac7766f319fadc2128d12941575c006e,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        kB0  = 128'h000102030405060708090a0b0c0d0e0f;
        kB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.rk_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rk_valid actual=1 expected=0 round=%0d", bus.rk_round);
                    end else begin
                        if (sb[0].chk) check("sb_rk", bus.rk, sb[0].rk);
                        check("sb_round", 128'(bus.rk_round), 128'(sb[0].rnd));
                        check("sb_last", 128'(bus.rk_last), 128'(sb[0].last));
                        if (bus.rk_ready) void'(sb.pop_front());
                    end
                end
            end
            stimulus();
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Sequential AES-128 round-key generator for the decryption datapath; the reverse-order counterpart of the forward key expansion.
- Accepts the cipher key and runs the forward schedule iteratively, one round key per cycle, to reach round key 10.
- Then streams round keys 10 down to 0 over a valid/ready interface, recomputing each earlier key by the inverse key-schedule step.
- Replaces the 1408-bit flat key array with a 128-bit working register.

Parameters:
- NK, 4, key length in 32-bit words; only 4 is supported.
- NR, 10, number of rounds; only 10 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- key  in  [0:127]  cipher key; sampled with start; word 0 is bits [0:31].
- busy  out  1  high in every state except IDLE.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts rk.
- rk  out  [0:127]  current round key, same word order as key.
- rk_round  out  4  round index of rk (10..0).
- rk_last  out  1  high with rk_valid when rk_round==0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: busy=0, rk_valid=0, rk=0, rk_round=0, rk_last=0, state=IDLE. rst mid-operation aborts immediately; no further outputs.
- States:
  - IDLE: on start, load key into work reg, rcnt=0, go to FWD.
  - FWD: each cycle applies the forward step with rcon(rcnt+1), then rcnt++. After the step producing rcnt==10, go to EMIT.
  - EMIT: rk_valid=1, rk=work reg, rk_round=rcnt.
    - On rk_valid&rk_ready with rcnt>0: apply the inverse step with rcon(rcnt), then rcnt--. rk_valid stays high with the next key on the following cycle, so the stream can sustain one key per cycle.
    - On handshake with rcnt==0: go to IDLE, and rk_valid, busy and rk_last drop the next cycle.
- Forward step (words w0..w3 → n0..n3):
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ rcon
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
- Inverse step (words n0..n3 → w0..w3):
  - w3 = n3 ^ n2
  - w2 = n2 ^ n1
  - w1 = n1 ^ n0
  - w0 = n0 ^ SubWord(RotWord(w3)) ^ rcon
- RotWord(a,b,c,d) = (b,c,d,a).
- rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the top byte, zeros below.
- SubWord resources: one 4-S-box SubWord instance only. Its input is muxed: w3 in FWD, (n3^n2) in EMIT.
- Latency: start accepted at edge E; first rk_valid is high after edge E+10, i.e. rk_valid is visible 11 cycles after the start cycle.
- Hold: while rk_valid & !rk_ready, rk, rk_round and rk_last are held stable.
- start while busy is ignored, with no restart.
- start coincident with rst: reset wins.
- All arithmetic is bitwise XOR; no width growth.

Optional Feature:
- Macro: AES_INV_KEY_EQ_INV_MIXCOL_EN.
- Defined:
  - rk for rounds 1..9 is InvMixColumns applied to each of the four words (columns). This serves the equivalent inverse cipher.
  - Rounds 10 and 0 are output unmodified.
  - The transform is combinational on the output; the working register is untouched and latency is unchanged.
- Undefined: rk is always the raw round key, and no InvMixColumns logic is present.

Decomposition:
- Package aes_pkg holds:
  - word typedef [0:31]
  - constants NK=4, NR=10
  - SBox function (the standard 256-entry table)
  - rcon function
  - RotWord function
  - gf_mul2 / gf_mul helpers, used only under the macro
- Sub-module aes_sub_word: four S-box lookups, 32-bit in and out, purely combinational, instantiated once.
- State machine, rcnt counter, working register and output mux live in aes_inv_key_sched.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1:
  - first rk_valid 11 cycles after start, rk=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_round=10;
  - next rk=ac7766f319fadc2128d12941575c006e, rk_round=9;
  - rk_round=1 gives a0fafe1788542cb123a339392a6c7605;
  - rk_round=0 gives the original key with rk_last=1;
  - 11 keys on consecutive cycles, then busy=0.
- Backpressure: hold rk_ready=0 for 5 cycles at round 7 → rk and rk_round stable throughout. Toggle rk_ready randomly → full sequence identical to the 11 expected keys in order.
- start asserted during FWD and during EMIT with a different key → ignored; the output stream matches the first key only.
- rst asserted mid-FWD (cycle 5) and mid-EMIT (round 4) → next cycle all outputs 0, IDLE. A subsequent start with key 000102030405060708090a0b0c0d0e0f yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: start on the cycle after the rk_last handshake → accepted, correct second sequence.
- With AES_INV_KEY_EQ_INV_MIXCOL_EN:
  - rounds 10 and 0 equal the raw values above;
  - rounds 1..9 equal the golden model's InvMixColumns(raw key);
  - latency unchanged.
